dmem_arb: RTL and testbench

Two-requester arbiter sharing the single data-cache port between the memory stage (port 0) and a secondary master (port 1, e.g. instruction-refill or debug loader). It presents a waitrequest-style read/write slave interface to each requester and drives one master interface of the same protocol into the cache. A registered owner state machine grants the port to one requester per transaction and holds the grant until the cache completes.

---
 rtl/dmem_arb.sv | 111 +++++++++++
 tb/tb_dmem_arb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dmem_arb.sv
// dmem_arb: two-port arbiter sharing one waitrequest-style data-cache port.
// Optional macro DMEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module dmem_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  p0_rd,
  input  logic                  p0_wr,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wr_data,
  input  logic [BE_WIDTH-1:0]   p0_wr_be,
  output logic [DATA_WIDTH-1:0] p0_data,
  output logic                  p0_waitrequest,
  input  logic                  p1_rd,
  input  logic                  p1_wr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wr_data,
  input  logic [BE_WIDTH-1:0]   p1_wr_be,
  output logic [DATA_WIDTH-1:0] p1_data,
  output logic                  p1_waitrequest,
  output logic                  cache_rd,
  output logic                  cache_wr,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wr_data,
  output logic [BE_WIDTH-1:0]   cache_wr_be,
  input  logic [DATA_WIDTH-1:0] cache_data,
  input  logic                  cache_waitrequest
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_last_grant;
  logic       w_p0_req;
  logic       w_p1_req;
  logic       w_grant1;

  assign w_p0_req = p0_rd | p0_wr;
  assign w_p1_req = p1_rd | p1_wr;

`ifdef DMEM_ARB_RR_EN
  // On a tie, the port that did not win last time goes next.
  assign w_grant1 = w_p1_req & (~w_p0_req | ~r_last_grant);
`else
  assign w_grant1 = w_p1_req & ~w_p0_req;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_p0_req | w_p1_req) w_state_nxt = w_grant1 ? ST_OWN1 : ST_OWN0;
      end
      // Release on completion, or if the owner abandons its request.
      ST_OWN0: if (!cache_waitrequest || !w_p0_req) w_state_nxt = ST_IDLE;
      ST_OWN1: if (!cache_waitrequest || !w_p1_req) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && (w_p0_req | w_p1_req)) r_last_grant <= w_grant1;
    end
  end

  // Data path is purely combinational from the owner; write masks read.
  always_comb begin
    cache_rd       = 1'b0;
    cache_wr       = 1'b0;
    cache_addr     = '0;
    cache_wr_data  = '0;
    cache_wr_be    = '0;
    p0_data        = '0;
    p1_data        = '0;
    p0_waitrequest = 1'b1;
    p1_waitrequest = 1'b1;
    case (r_state)
      ST_OWN0: begin
        cache_rd       = p0_rd & ~p0_wr;
        cache_wr       = p0_wr;
        cache_addr     = p0_addr;
        cache_wr_data  = p0_wr_data;
        cache_wr_be    = p0_wr_be;
        p0_data        = cache_data;
        p0_waitrequest = cache_waitrequest;
      end
      ST_OWN1: begin
        cache_rd       = p1_rd & ~p1_wr;
        cache_wr       = p1_wr;
        cache_addr     = p1_addr;
        cache_wr_data  = p1_wr_data;
        cache_wr_be    = p1_wr_be;
        p1_data        = cache_data;
        p1_waitrequest = cache_waitrequest;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arb.sv
// Directed self-checking bench for dmem_arb; honours DMEM_ARB_RR_EN when defined.
module tb_dmem_arb;

  logic        clock;
  logic        reset_n;
  logic        p0_rd, p0_wr, p1_rd, p1_wr;
  logic [31:0] p0_addr, p0_wr_data, p1_addr, p1_wr_data;
  logic [3:0]  p0_wr_be, p1_wr_be;
  logic [31:0] p0_data, p1_data;
  logic        p0_waitrequest, p1_waitrequest;
  logic        cache_rd, cache_wr;
  logic [31:0] cache_addr, cache_wr_data;
  logic [3:0]  cache_wr_be;
  logic [31:0] cache_data;
  logic        cache_waitrequest;

  int n_checks = 0;
  int n_errors = 0;

  dmem_arb dut (
    .clock(clock), .reset_n(reset_n),
    .p0_rd(p0_rd), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
    .p0_wr_be(p0_wr_be), .p0_data(p0_data), .p0_waitrequest(p0_waitrequest),
    .p1_rd(p1_rd), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
    .p1_wr_be(p1_wr_be), .p1_data(p1_data), .p1_waitrequest(p1_waitrequest),
    .cache_rd(cache_rd), .cache_wr(cache_wr), .cache_addr(cache_addr),
    .cache_wr_data(cache_wr_data), .cache_wr_be(cache_wr_be),
    .cache_data(cache_data), .cache_waitrequest(cache_waitrequest)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Owner-visible snapshot: {p0_wait, p1_wait, cache_rd, cache_wr}
  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {p0_waitrequest, p1_waitrequest, cache_rd, cache_wr}, 4'b1100);
    check({tag, "_addr"}, cache_addr, 32'h0);
  endtask

  initial begin
    logic [3:0] exp_own;
    reset_n = 1'b0;
    {p0_rd, p0_wr, p1_rd, p1_wr} = 4'b0;
    p0_addr = 0; p0_wr_data = 0; p0_wr_be = 0;
    p1_addr = 0; p1_wr_data = 0; p1_wr_be = 0;
    cache_data = 0; cache_waitrequest = 1'b1;
    #2;
    check_idle("rst_hold");
    check("rst_data", {p0_data, p1_data}, 64'h0);
    step(); step();
    reset_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      #1 check_idle("idle");
      step();
    end

    // Single zero-wait read on port 0
    p0_rd = 1'b1; p0_addr = 32'h100;
    cache_waitrequest = 1'b0; cache_data = 32'hDEADBEEF;
    #1 check("rd_T0_crd", cache_rd, 1'b0);
    step();
    check("rd_T1_ctl", {p0_waitrequest, p1_waitrequest, cache_rd, cache_wr}, 4'b0110);
    check("rd_T1_addr", cache_addr, 32'h100);
    check("rd_T1_data", p0_data, 32'hDEADBEEF);
    check("rd_T1_p1data", p1_data, 32'h0);
    step();
    p0_rd = 1'b0; p0_addr = 0;
    #1 check_idle("rd_T2");

    // Port 1 write with three stall cycles
    p1_wr = 1'b1; p1_addr = 32'h200; p1_wr_data = 32'h12345678; p1_wr_be = 4'b0011;
    cache_waitrequest = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      cache_waitrequest = (i == 3) ? 1'b0 : 1'b1;
      #1;
      check("wr_ctl", {p0_waitrequest, p1_waitrequest, cache_rd, cache_wr},
            (i == 3) ? 4'b1001 : 4'b1101);
      check("wr_bus", {cache_addr, cache_wr_data}, {32'h200, 32'h12345678});
      check("wr_be", cache_wr_be, 4'b0011);
      check("wr_p0data", p0_data, 32'h0);
      step();
    end
    p1_wr = 1'b0; p1_addr = 0; p1_wr_data = 0; p1_wr_be = 0;
    #1 check_idle("wr_end");

    // Contention, zero wait; last winner was port 1
    p0_rd = 1'b1; p0_addr = 32'h300;
    p1_rd = 1'b1; p1_addr = 32'h400;
    cache_waitrequest = 1'b0;
    for (int t = 0; t < 4; t++) begin
      #1 check_idle("cont_gap");
      step();
`ifdef DMEM_ARB_RR_EN
      exp_own = (t % 2 == 0) ? 4'b0110 : 4'b1010;
      check("cont_addr", cache_addr, (t % 2 == 0) ? 32'h300 : 32'h400);
`else
      exp_own = 4'b0110;
      check("cont_addr", cache_addr, 32'h300);
`endif
      check("cont_ctl", {p0_waitrequest, p1_waitrequest, cache_rd, cache_wr}, exp_own);
      step();
    end
    p1_rd = 1'b0; p1_addr = 0;
    p0_rd = 1'b0;
    #1 check_idle("cont_end");

    // Reset during a stalled port 0 transaction
    p0_rd = 1'b1; p0_addr = 32'h500; cache_waitrequest = 1'b1;
    step();
    check("rstmid_own", {p0_waitrequest, cache_rd, cache_addr}, {1'b1, 1'b1, 32'h500});
    reset_n = 1'b0;
    #1 check_idle("rstmid_async");
    step();
    reset_n = 1'b1;
    #1 check_idle("rstmid_rel");
    step();
    check("rstmid_regrant", {cache_rd, cache_addr}, {1'b1, 32'h500});
    cache_waitrequest = 1'b0;
    #1 check("rstmid_done", p0_waitrequest, 1'b0);
    step();
    p0_rd = 1'b0;

    // Simultaneous rd and wr on port 0: write wins
    p0_rd = 1'b1; p0_wr = 1'b1; p0_addr = 32'h600;
    step();
    check("rdwr_ctl", {p0_waitrequest, p1_waitrequest, cache_rd, cache_wr}, 4'b0101);
    step();
    p0_rd = 1'b0; p0_wr = 1'b0;
    #1 check_idle("rdwr_end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
